// File: rtl/index_stack_pkg.sv
// Shared constants and types for the LIFO index stack: default geometry
// plus the data and pointer types sized from those defaults.
package index_stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_IDX_W = $clog2(DEF_DEPTH);
    localparam int DEF_PTR_W = DEF_IDX_W + 1;

    typedef logic [DEF_WIDTH-1:0] data_t;
    typedef logic [DEF_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/index_stack_if.sv
// Push/pop/peek bus of the index stack; master drives requests, slave
// (the stack) returns data, occupancy and error status.
interface index_stack_if
    import index_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_data;
    logic             pop_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic [IDX_W-1:0] peek_idx;
    logic [WIDTH-1:0] peek_data;
    logic             peek_err;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output push_valid, push_data, pop_ready, peek_idx,
        input  push_ready, pop_valid, pop_data, peek_data, peek_err,
               count, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  push_valid, push_data, pop_ready, peek_idx,
        output push_ready, pop_valid, pop_data, peek_data, peek_err,
               count, full, empty, ovf_err, unf_err
    );

endinterface

// File: rtl/index_stack.sv
// Register-based LIFO with simultaneous push/pop (replace-top), random
// peek below the top, and sticky overflow/underflow flags.
module index_stack
    import index_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          reset_l,
    index_stack_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full_s;
    logic             empty_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] peek_pos_s;
    logic             peek_err_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;

    assign full_s    = (ptr_q == PTR_W'(DEPTH));
    assign empty_s   = (ptr_q == {PTR_W{1'b0}});
    assign top_idx_s = IDX_W'(ptr_q - PTR_W'(1));

    // Peek index is widened to the pointer width so an out-of-range index
    // is flagged instead of wrapping onto entries above the top.
    assign peek_err_s = ({1'b0, bus.peek_idx} >= ptr_q);
    assign peek_pos_s = IDX_W'(ptr_q - PTR_W'(1) - {1'b0, bus.peek_idx});

    assign bus.push_ready = ~full_s | bus.pop_ready;
    assign bus.pop_valid  = ~empty_s;
    assign bus.pop_data   = empty_s ? {WIDTH{1'b0}} : mem_q[top_idx_s];
    assign bus.peek_err   = peek_err_s;
    assign bus.peek_data  = peek_err_s ? {WIDTH{1'b0}} : mem_q[peek_pos_s];
    assign bus.count      = CNT_W'(ptr_q);
    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.ovf_err    = ovf_q;
    assign bus.unf_err    = unf_q;

    // Next pointer, error flags and memory write port from the request pair.
    always_comb begin
        ptr_d    = ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_en_s  = 1'b0;
        wr_idx_s = ptr_q[IDX_W-1:0];
        case ({bus.push_valid, bus.pop_ready})
            2'b11: begin
                wr_en_s = 1'b1;
                if (empty_s) begin
                    ptr_d = ptr_q + PTR_W'(1);
                end else begin
                    wr_idx_s = top_idx_s;
                end
            end
            2'b10: begin
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                end
            end
            2'b01: begin
                if (empty_s) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d = ptr_q - PTR_W'(1);
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Pointer and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            ptr_q <= {PTR_W{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; left uninitialised, only entries below ptr are visible.
    always_ff @(posedge clk) begin
        if (reset_l && wr_en_s) begin
            mem_q[wr_idx_s] <= bus.push_data;
        end else begin
            mem_q[wr_idx_s] <= mem_q[wr_idx_s];
        end
    end

endmodule

// File: tb/tb_index_stack.sv
// Directed bench for index_stack: a queue-based LIFO model is checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_index_stack;
    import index_stack_pkg::*;

    localparam int DEPTH = DEF_DEPTH;

    logic clk;
    logic reset_l;
    int   checks;
    int   failures;

    index_stack_if #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH)) bus ();

    index_stack #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_t q[$];
    logic  m_ovf;
    logic  m_unf;
    logic  model_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LIFO: updated from the sampled requests on each rising edge.
    always @(posedge clk) begin
        if (!reset_l) begin
            q.delete();
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (bus.push_valid && bus.pop_ready) begin
                if (q.size() == 0) q.push_back(bus.push_data);
                else q[q.size()-1] = bus.push_data;
            end else if (bus.push_valid) begin
                if (q.size() == DEPTH) m_ovf = 1'b1;
                else q.push_back(bus.push_data);
            end else if (bus.pop_ready) begin
                if (q.size() == 0) m_unf = 1'b1;
                else void'(q.pop_back());
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            int    sz;
            int    pi;
            data_t exp_top;
            data_t exp_peek;
            sz       = q.size();
            pi       = int'(bus.peek_idx);
            exp_top  = (sz > 0) ? q[sz-1] : '0;
            exp_peek = (pi < sz) ? q[sz-1-pi] : '0;
            check("count",      32'(bus.count),      32'(ptr_t'(sz)));
            check("empty",      32'(bus.empty),      32'(sz == 0));
            check("full",       32'(bus.full),       32'(sz == DEPTH));
            check("pop_valid",  32'(bus.pop_valid),  32'(sz != 0));
            check("pop_data",   32'(bus.pop_data),   32'(exp_top));
            check("peek_data",  32'(bus.peek_data),  32'(exp_peek));
            check("peek_err",   32'(bus.peek_err),   32'(pi >= sz));
            check("push_ready", 32'(bus.push_ready), 32'((sz < DEPTH) || bus.pop_ready));
            check("ovf_err",    32'(bus.ovf_err),    32'(m_ovf));
            check("unf_err",    32'(bus.unf_err),    32'(m_unf));
        end
    end

    task automatic tick(input logic rst, input logic pv, input logic [7:0] pd,
                        input logic pr, input logic [2:0] pi);
        @(posedge clk);
        #1;
        reset_l        = rst;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
        bus.peek_idx   = pi;
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] pi);
        tick(1'b1, 1'b0, 8'h00, 1'b0, pi);
    endtask

    task automatic push(input logic [7:0] d);
        tick(1'b1, 1'b1, d, 1'b0, 3'd0);
    endtask

    task automatic pop();
        tick(1'b1, 1'b0, 8'h00, 1'b1, 3'd0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        model_valid    = 1'b0;
        m_ovf          = 1'b0;
        m_unf          = 1'b0;
        reset_l        = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = 8'h00;
        bus.pop_ready  = 1'b0;
        bus.peek_idx   = 3'd0;

        // Reset values
        do_reset();
        do_reset();
        check("rst_count",      32'(bus.count),      32'd0);
        check("rst_empty",      32'(bus.empty),      32'd1);
        check("rst_full",       32'(bus.full),       32'd0);
        check("rst_pop_data",   32'(bus.pop_data),   32'h00);
        check("rst_peek_err",   32'(bus.peek_err),   32'd1);
        check("rst_push_ready", 32'(bus.push_ready), 32'd1);

        // Basic LIFO order
        push(8'h11);
        push(8'h22);
        push(8'h33);
        idle(3'd0);
        check("lifo_count", 32'(bus.count),    32'd3);
        check("lifo_top",   32'(bus.pop_data), 32'h33);
        pop();
        check("lifo_pop0", 32'(bus.pop_data), 32'h33);
        pop();
        check("lifo_pop1", 32'(bus.pop_data), 32'h22);
        pop();
        check("lifo_pop2", 32'(bus.pop_data), 32'h11);
        idle(3'd0);
        check("lifo_empty", 32'(bus.empty),   32'd1);
        check("lifo_unf",   32'(bus.unf_err), 32'd0);

        // Fill, then overflow
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        idle(3'd0);
        check("fill_full", 32'(bus.full), 32'd1);
        push(8'hAA);
        check("ovf_push_ready", 32'(bus.push_ready), 32'd0);
        idle(3'd0);
        check("ovf_flag",  32'(bus.ovf_err),  32'd1);
        check("ovf_top",   32'(bus.pop_data), 32'h07);
        check("ovf_count", 32'(bus.count),    32'd8);
        tick(1'b1, 1'b1, 8'h99, 1'b1, 3'd0);
        check("full_rep_ready", 32'(bus.push_ready), 32'd1);
        check("full_rep_old",   32'(bus.pop_data),   32'h07);
        idle(3'd7);
        check("full_rep_top",  32'(bus.pop_data),  32'h99);
        check("full_rep_peek", 32'(bus.peek_data), 32'h00);

        // Replace-top with simultaneous push/pop, then peeks
        do_reset();
        push(8'h01);
        push(8'h02);
        tick(1'b1, 1'b1, 8'h55, 1'b1, 3'd0);
        check("rep_old_top", 32'(bus.pop_data), 32'h02);
        idle(3'd1);
        check("rep_count", 32'(bus.count),     32'd2);
        check("rep_top",   32'(bus.pop_data),  32'h55);
        check("rep_peek1", 32'(bus.peek_data), 32'h01);
        push(8'h03);
        idle(3'd2);
        check("peek2_data", 32'(bus.peek_data), 32'h01);
        check("peek2_err",  32'(bus.peek_err),  32'd0);
        idle(3'd3);
        check("peek3_data", 32'(bus.peek_data), 32'h00);
        check("peek3_err",  32'(bus.peek_err),  32'd1);

        // Underflow, then push+pop on an empty stack
        do_reset();
        pop();
        idle(3'd0);
        check("unf_flag",  32'(bus.unf_err), 32'd1);
        check("unf_count", 32'(bus.count),   32'd0);
        tick(1'b1, 1'b1, 8'h77, 1'b1, 3'd0);
        idle(3'd0);
        check("emp_pp_count", 32'(bus.count),    32'd1);
        check("emp_pp_top",   32'(bus.pop_data), 32'h77);

        // Reset during a push overrides it
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 5; i++) push(8'hE0);
        idle(3'd0);
        check("pre_rst_count", 32'(bus.count), 32'd8);
        pop(); pop(); pop();
        idle(3'd0);
        check("pre_rst_five", 32'(bus.count), 32'd5);
        tick(1'b0, 1'b1, 8'hBB, 1'b0, 3'd0);
        idle(3'd0);
        check("mid_rst_count", 32'(bus.count),   32'd0);
        check("mid_rst_empty", 32'(bus.empty),   32'd1);
        check("mid_rst_ovf",   32'(bus.ovf_err), 32'd0);
        check("mid_rst_unf",   32'(bus.unf_err), 32'd0);
        idle(3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
